// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width encodings and funct3 legality/alignment checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic isLegal(input logic store, input logic [2:0] funct3);
    if (store)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned one.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Formats the raw memory word into an RV32I load result (sign/zero extension).
// Lane 0 is always the addressed byte, because memory returns addr..addr+3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] memRData,
  output logic [31:0] loadData
);

  always_comb begin
    loadData = 32'd0;
    case (funct3)
      F3_B:    loadData = {{24{memRData[7]}}, memRData[7:0]};
      F3_H:    loadData = {{16{memRData[15]}}, memRData[15:0]};
      F3_W:    loadData = memRData;
      F3_BU:   loadData = {24'd0, memRData[7:0]};
      F3_HU:   loadData = {16'd0, memRData[15:0]};
      default: loadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer; sub-word stores become read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqStore,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respErr,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic        memRW,
  input  logic [31:0] memRData
);

  // The full 32-bit address goes out unchanged; memory wraps on its own.
  if (MEM_AW > 32) begin : g_aw_too_wide
  end

  lsu_state_t  state_reg, state_next;
  logic        store_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merged_reg;
  logic [31:0] resp_data_reg;
  logic        resp_err_reg;
  logic [31:0] load_data;
  logic        accept;
  logic        req_err;

  assign accept = reqValid && (state_reg == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = !isLegal(reqStore, reqFunct3) || isMisaligned(reqFunct3, reqAddr[1:0]);
`else
  assign req_err = !isLegal(reqStore, reqFunct3);
`endif

  lsu_load_align u_align (
    .funct3   (funct3_reg),
    .memRData (memRData),
    .loadData (load_data)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (reqValid) begin
          if (req_err)                 state_next = RESP;
          else if (!reqStore)          state_next = LOAD;
          else if (reqFunct3 == F3_W)  state_next = WRITE;
          else                         state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    if (respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_reg == IDLE);
    respValid = (state_reg == RESP);
    memRW     = (state_reg == WRITE);
    memAddr   = (state_reg == IDLE)  ? 32'd0 : addr_reg;
    memWData  = (state_reg == WRITE) ? merged_reg : 32'd0;
    respData  = resp_data_reg;
    respErr   = resp_err_reg;
  end

  // Response fields are cleared on accept so stores and errors report zero data.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      store_reg     <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      merged_reg    <= 32'd0;
      resp_data_reg <= 32'd0;
      resp_err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        store_reg     <= reqStore;
        funct3_reg    <= reqFunct3;
        addr_reg      <= reqAddr;
        wdata_reg     <= reqWData;
        merged_reg    <= reqWData;
        resp_data_reg <= 32'd0;
        resp_err_reg  <= req_err;
      end
      if (state_reg == LOAD)
        resp_data_reg <= load_data;
      if (state_reg == RMW_RD) begin
        if (funct3_reg == F3_H) merged_reg <= {memRData[31:16], wdata_reg[15:0]};
        else                    merged_reg <= {memRData[31:8],  wdata_reg[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model and
// a scoreboard of expected responses; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  localparam int MEM_AW = 12;
  localparam int MASK   = (1 << MEM_AW) - 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          wr_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqReady, reqStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWData;
  logic        respValid, respReady, respErr;
  logic [31:0] respData, memAddr, memWData, memRData;
  logic        memRW;

  logic [7:0]  mem [0:MASK];
  logic        preload_done = 1'b0;
  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .memAddr(memAddr), .memWData(memWData), .memRW(memRW), .memRData(memRData)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem[(a + 3) & MASK], mem[(a + 2) & MASK], mem[(a + 1) & MASK], mem[a & MASK]};
  endfunction

  assign memRData = rd_word(memAddr);

  // Memory model: one-time preload, then whole-word writes when memRW is high at the edge.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i <= MASK; i++) mem[i] <= 8'h00;
      {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} <= 32'h8899AABB;
      {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} <= 32'h000080F0;
      {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} <= 32'h11223344;
      {mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]} <= 32'h55667788;
      preload_done <= 1'b1;
    end else if (memRW) begin
      mem[memAddr & MASK]       <= memWData[7:0];
      mem[(memAddr + 1) & MASK] <= memWData[15:8];
      mem[(memAddr + 2) & MASK] <= memWData[23:16];
      mem[(memAddr + 3) & MASK] <= memWData[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] e_data, input logic e_err,
                     input int e_lat, input int e_wr, input int hold);
    exp_t e;
    int   lat, wr_cnt, wr_at;
    e.data = e_data; e.err = e_err; e.lat = e_lat; e.wr_at = e_wr;
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, ".reqReady"}, {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqStore = st; reqFunct3 = f3; reqAddr = a; reqWData = wd;
    @(posedge clk);
    lat = 0; wr_cnt = 0; wr_at = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) reqValid = 1'b0;
      if (memRW) begin wr_cnt++; wr_at = k; end
      if (respValid) lat = k;
    end
    e = sb_q.pop_front();
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".respData"}, respData, e.data);
    chk({tag, ".respErr"}, {31'd0, respErr}, {31'd0, e.err});
    chk({tag, ".writes"}, wr_cnt, (e.wr_at != 0) ? 1 : 0);
    chk({tag, ".writeEdge"}, wr_at, e.wr_at);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".holdValid"}, {31'd0, respValid}, 32'd1);
      chk({tag, ".holdData"}, respData, e.data);
      chk({tag, ".holdReady"}, {31'd0, reqReady}, 32'd0);
    end
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    chk({tag, ".doneValid"}, {31'd0, respValid}, 32'd0);
    chk({tag, ".doneReady"}, {31'd0, reqReady}, 32'd1);
    $display("txn %s store=%0d f3=%0d addr=0x%08h lat=%0d data=0x%08h err=%0d",
             tag, st, f3, a, lat, respData, respErr);
  endtask

  initial begin
    rstN = 1'b0; reqValid = 1'b0; reqStore = 1'b0; reqFunct3 = 3'd0;
    reqAddr = 32'd0; reqWData = 32'd0; respReady = 1'b0;
    #12;
    chk("rst.reqReady",  {31'd0, reqReady},  32'd1);
    chk("rst.respValid", {31'd0, respValid}, 32'd0);
    chk("rst.respData",  respData,           32'd0);
    chk("rst.respErr",   {31'd0, respErr},   32'd0);
    chk("rst.memRW",     {31'd0, memRW},     32'd0);
    chk("rst.memAddr",   memAddr,            32'd0);
    chk("rst.memWData",  memWData,           32'd0);
    @(negedge clk);
    rstN = 1'b1;

    txn("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 0);
    txn("lb20",  1'b0, 3'd0, 32'h20, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 0, 0);
    txn("lbu20", 1'b0, 3'd4, 32'h20, 32'h0, 32'h000000F0, 1'b0, 2, 0, 0);
    txn("lh20",  1'b0, 3'd1, 32'h20, 32'h0, 32'hFFFF80F0, 1'b0, 2, 0, 0);
    txn("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, 32'h000080F0, 1'b0, 2, 0, 0);

    txn("sb40", 1'b1, 3'd0, 32'h40, 32'h000000AB, 32'h0, 1'b0, 3, 2, 0);
    chk("sb40.mem", rd_word(32'h40), 32'h112233AB);
    txn("sh40", 1'b1, 3'd1, 32'h40, 32'h0000BEEF, 32'h0, 1'b0, 3, 2, 0);
    txn("lw40a", 1'b0, 3'd2, 32'h40, 32'h0, 32'h1122BEEF, 1'b0, 2, 0, 0);
    txn("sw40", 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 5);
    txn("lw40b", 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 0);

    txn("errld3", 1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("errst4", 1'b1, 3'd4, 32'h40, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
    chk("errst4.mem", rd_word(32'h40), 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
    txn("lw41", 1'b0, 3'd2, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
    txn("lw41", 1'b0, 3'd2, 32'h41, 32'h0, 32'h88CAFEF0, 1'b0, 2, 0, 0);
`endif

    // Reset while a word write is pending must cancel it.
    @(negedge clk);
    reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'd2; reqAddr = 32'h40; reqWData = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    chk("abort.memRWbefore", {31'd0, memRW}, 32'd1);
    rstN = 1'b0;
    #1;
    chk("abort.memRW",    {31'd0, memRW},    32'd0);
    chk("abort.memAddr",  memAddr,           32'd0);
    chk("abort.reqReady", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    chk("abort.mem",       rd_word(32'h40),    32'hCAFEF00D);
    chk("abort.respValid", {31'd0, respValid}, 32'd0);
    $display("txn abort store=1 f3=2 addr=0x00000040 dropped");

    txn("lw40c", 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
